// File: rtl/spi_xfer_seq_if.sv
// rtl/spi_xfer_seq_if.sv - host and byte-engine signal bundle for the SPI transaction sequencer
interface spi_xfer_seq_if #(
    parameter int DEPTH = 16,
    parameter int LEN_W = 8
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic             buf_wr_en;
    logic [7:0]       buf_wr_data;
    logic [CW-1:0]    buf_cnt;
    logic             buf_full;
    logic             cmd_start;
    logic [LEN_W-1:0] wr_len;
    logic [LEN_W-1:0] rd_len;
    logic             busy;
    logic             done;
    logic             err;
    logic [7:0]       rd_data;
    logic             rd_valid;
    logic             spi_start;
    logic             spi_end;
    logic [7:0]       data_send;
    logic             send_done;
    logic             rec_done;
    logic [7:0]       data_rec;
    logic             spi_cs;

    modport master (
        output buf_wr_en, buf_wr_data, cmd_start, wr_len, rd_len,
        output send_done, rec_done, data_rec, spi_cs,
        input  buf_cnt, buf_full, busy, done, err, rd_data, rd_valid,
        input  spi_start, spi_end, data_send
    );

    modport slave (
        input  buf_wr_en, buf_wr_data, cmd_start, wr_len, rd_len,
        input  send_done, rec_done, data_rec, spi_cs,
        output buf_cnt, buf_full, busy, done, err, rd_data, rd_valid,
        output spi_start, spi_end, data_send
    );
endinterface

// File: rtl/spi_xfer_seq.sv
// rtl/spi_xfer_seq.sv - CS-framed write-then-read transaction sequencer over the SPI byte engine
module spi_xfer_seq #(
    parameter int         DEPTH      = 16,
    parameter int         LEN_W      = 8,
    parameter logic [7:0] DUMMY_BYTE = 8'hFF
) (
    input  logic         sys_clk,
    input  logic         sys_rst_n,
    spi_xfer_seq_if.slave bus
);
    localparam int AW   = $clog2(DEPTH);
    localparam int CW   = AW + 1;
    localparam int TW   = LEN_W + 1;
    localparam int CMPW = (TW > CW) ? TW : CW;

    typedef enum logic [2:0] {IDLE, LAUNCH, XFER, WAIT_CS, FIN} state_t;
    state_t state_q, state_d;

    logic [7:0]      mem [DEPTH];
    logic [CW-1:0]   cnt_q;
    logic [TW-1:0]   total_q, wr_len_q, tx_idx, rx_idx;
    logic [TW-1:0]   tx_next, cmd_total;
    logic [CMPW-1:0] wr_ext, cnt_ext;
    logic [7:0]      data_send_q, rd_data_q;
    logic            rd_valid_q, spi_start_q, spi_end_q, err_q;
    logic            cmd_ok, cmd_go, cmd_bad, buf_push, buf_full_w, last_rec;

    assign cmd_total  = TW'(bus.wr_len) + TW'(bus.rd_len);
    assign wr_ext     = CMPW'(bus.wr_len);
    assign cnt_ext    = CMPW'(cnt_q);
    assign cmd_ok     = (cmd_total != '0) && (wr_ext <= cnt_ext);
    assign cmd_go     = (state_q == IDLE) && bus.cmd_start && cmd_ok;
    assign cmd_bad    = (state_q == IDLE) && bus.cmd_start && !cmd_ok;
    assign buf_full_w = (cnt_q == CW'(DEPTH));
    assign buf_push   = (state_q == IDLE) && bus.buf_wr_en && !buf_full_w;
    assign tx_next    = tx_idx + TW'(1);
    assign last_rec   = bus.rec_done && (rx_idx + TW'(1) == total_q);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) state_q <= IDLE;
        else            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cmd_go) state_d = LAUNCH;
            LAUNCH:  state_d = XFER;
            XFER:    if (last_rec) state_d = WAIT_CS;
            WAIT_CS: if (bus.spi_cs) state_d = FIN;
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Buffer contents need no reset; only the fill count defines validity.
    always_ff @(posedge sys_clk) begin
        if (buf_push) mem[cnt_q[AW-1:0]] <= bus.buf_wr_data;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt_q       <= '0;
            total_q     <= '0;
            wr_len_q    <= '0;
            tx_idx      <= '0;
            rx_idx      <= '0;
            data_send_q <= '0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            spi_start_q <= 1'b0;
            spi_end_q   <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            err_q       <= cmd_bad;
            spi_start_q <= 1'b0;
            spi_end_q   <= 1'b0;
            rd_valid_q  <= 1'b0;
            if (buf_push) cnt_q <= cnt_q + CW'(1);
            if (state_q == FIN) cnt_q <= '0;
            if (cmd_go) begin
                total_q  <= cmd_total;
                wr_len_q <= TW'(bus.wr_len);
                tx_idx   <= '0;
                rx_idx   <= '0;
            end
            if (state_q == LAUNCH) begin
                spi_start_q <= 1'b1;
                data_send_q <= (wr_len_q != '0) ? mem[0] : DUMMY_BYTE;
            end
            if (state_q == XFER) begin
                // The next byte is staged a cycle after send_done; the final send_done ends the frame instead.
                if (bus.send_done) begin
                    tx_idx <= tx_next;
                    if (tx_next < total_q)
                        data_send_q <= (tx_next < wr_len_q) ? mem[tx_next[AW-1:0]] : DUMMY_BYTE;
                    else
                        spi_end_q <= 1'b1;
                end
                if (bus.rec_done) begin
                    rx_idx <= rx_idx + TW'(1);
                    if (rx_idx >= wr_len_q) begin
                        rd_data_q  <= bus.data_rec;
                        rd_valid_q <= 1'b1;
                    end
                end
            end
        end
    end

    assign bus.buf_cnt   = cnt_q;
    assign bus.buf_full  = buf_full_w;
    assign bus.busy      = (state_q == LAUNCH) || (state_q == XFER) || (state_q == WAIT_CS);
    assign bus.done      = (state_q == FIN);
    assign bus.err       = err_q;
    assign bus.rd_data   = rd_data_q;
    assign bus.rd_valid  = rd_valid_q;
    assign bus.spi_start = spi_start_q;
    assign bus.spi_end   = spi_end_q;
    assign bus.data_send = data_send_q;
endmodule

// File: tb/tb_spi_xfer_seq.sv
// tb/tb_spi_xfer_seq.sv - bench for spi_xfer_seq with a cycle-level byte engine and transaction model
module tb_spi_xfer_seq;
    typedef logic [7:0] bq_t [$];

    logic sys_clk = 1'b0;
    logic sys_rst_n;
    always #5 sys_clk = ~sys_clk;

    spi_xfer_seq_if #(.DEPTH(16), .LEN_W(8)) sif ();
    spi_xfer_seq #(.DEPTH(16), .LEN_W(8), .DUMMY_BYTE(8'hFF)) dut (
        .sys_clk  (sys_clk),
        .sys_rst_n(sys_rst_n),
        .bus      (sif)
    );

    int checks = 0;
    int errors = 0;

    // byte engine: 32 clocks per byte, send_done at 30, rec_done at 32
    int   cyc, tail, eng_bytes, rsp_base;
    bit   eng_act, end_seen;
    int   start_cnt = 0, end_cnt = 0, end_bad = 0, cs_low = 0;
    bq_t  sent_q, rsp_q;

    always @(negedge sys_clk) begin
        if (!sys_rst_n) begin
            eng_act = 0; end_seen = 0; tail = 0; cyc = 0;
            sif.spi_cs = 1'b1; sif.send_done = 1'b0; sif.rec_done = 1'b0; sif.data_rec = 8'h00;
        end else begin
            sif.send_done = 1'b0;
            sif.rec_done  = 1'b0;
            if (sif.spi_start) begin
                start_cnt++;
                if (sif.spi_end) end_bad++;
            end
            if (!sif.spi_cs) cs_low++;
            if (!eng_act) begin
                if (sif.spi_end) begin end_cnt++; end_bad++; end
                if (sif.spi_start) begin
                    eng_act = 1; sif.spi_cs = 1'b0; cyc = 0; end_seen = 0; tail = 0;
                end
            end else if (tail > 0) begin
                if (sif.spi_end) begin end_cnt++; end_bad++; end
                tail--;
                if (tail == 0) begin sif.spi_cs = 1'b1; eng_act = 0; end
            end else begin
                cyc++;
                if (sif.spi_end) begin
                    end_cnt++;
                    if (cyc == 31) end_seen = 1; else end_bad++;
                end
                if (cyc == 28) sent_q.push_back(sif.data_send);
                if (cyc == 30) sif.send_done = 1'b1;
                if (cyc == 32) begin
                    sif.rec_done = 1'b1;
                    sif.data_rec = ((eng_bytes - rsp_base) < rsp_q.size()) ? rsp_q[eng_bytes - rsp_base] : 8'h00;
                    eng_bytes++;
                    cyc = 0;
                    if (end_seen) tail = 2;
                end
            end
        end
    end

    // host-side monitor
    bq_t rx_q;
    int  done_cnt = 0, err_cnt = 0, busy_at_done = 0;
    always @(negedge sys_clk) begin
        if (sif.rd_valid) rx_q.push_back(sif.rd_data);
        if (sif.done) begin done_cnt++; if (sif.busy) busy_at_done++; end
        if (sif.err) err_cnt++;
    end

    bq_t mbuf;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic write_byte(input logic [7:0] b);
        @(negedge sys_clk);
        sif.buf_wr_en = 1'b1; sif.buf_wr_data = b;
        @(negedge sys_clk);
        sif.buf_wr_en = 1'b0;
        if (mbuf.size() < 16) mbuf.push_back(b);
    endtask

    task automatic run_cmd(input int wr, input int rd, input bq_t rsp_in, input bit poke, input bit chk_cs);
        int total, n, budget, s0, e0, b0, d0, r0, c0, bd0, sb, rb;
        bit exp_err;
        bq_t exp_tx, exp_rx;
        total   = wr + rd;
        exp_err = (total == 0) || (wr > mbuf.size());
        if (!exp_err) begin
            for (int i = 0; i < wr; i++) exp_tx.push_back(mbuf[i]);
            for (int i = 0; i < rd; i++) exp_tx.push_back(8'hFF);
            for (int i = wr; i < total; i++) exp_rx.push_back(rsp_in[i]);
        end
        s0 = start_cnt; e0 = end_cnt; b0 = end_bad; d0 = done_cnt; r0 = err_cnt;
        c0 = cs_low; bd0 = busy_at_done; sb = sent_q.size(); rb = rx_q.size();
        rsp_q = rsp_in; rsp_base = eng_bytes;
        budget = total * 32 + 40;

        @(negedge sys_clk);
        sif.cmd_start = 1'b1; sif.wr_len = 8'(wr); sif.rd_len = 8'(rd);
        @(negedge sys_clk);
        sif.cmd_start = 1'b0;
        if (exp_err) begin
            check("err_pulse", sif.err, 1);
            check("err_busy", sif.busy, 0);
        end else begin
            check("busy_rise", sif.busy, 1);
            check("start_early", sif.spi_start, 0);
            @(negedge sys_clk);
            check("start_latency", sif.spi_start, 1);
        end

        n = 0;
        while ((done_cnt - d0) == 0 && (err_cnt - r0) == 0 && n < budget) begin
            @(negedge sys_clk);
            n++;
            if (poke && n == 40) begin
                sif.buf_wr_en = 1'b1; sif.buf_wr_data = 8'h5A;
                sif.cmd_start = 1'b1; sif.wr_len = 8'd1; sif.rd_len = 8'd1;
            end
            if (poke && n == 41) begin
                sif.buf_wr_en = 1'b0; sif.cmd_start = 1'b0;
                check("busy_write_dropped", sif.buf_cnt, mbuf.size());
            end
        end
        check("timeout", n < budget, 1);
        repeat (4) @(negedge sys_clk);

        if (exp_err) begin
            check("err_count", err_cnt - r0, 1);
            check("err_no_start", start_cnt - s0, 0);
            check("err_no_done", done_cnt - d0, 0);
            check("err_buf_kept", sif.buf_cnt, mbuf.size());
        end else begin
            check("start_count", start_cnt - s0, 1);
            check("end_count", end_cnt - e0, 1);
            check("end_timing", end_bad - b0, 0);
            check("done_count", done_cnt - d0, 1);
            check("busy_at_done", busy_at_done - bd0, 0);
            check("err_none", err_cnt - r0, 0);
            check("busy_after", sif.busy, 0);
            check("buf_cleared", sif.buf_cnt, 0);
            check("tx_len", sent_q.size() - sb, total);
            for (int i = 0; i < total && sb + i < sent_q.size(); i++)
                check($sformatf("tx_byte%0d", i), sent_q[sb + i], exp_tx[i]);
            check("rx_len", rx_q.size() - rb, rd);
            for (int i = 0; i < rd && rb + i < rx_q.size(); i++)
                check($sformatf("rx_byte%0d", i), rx_q[rb + i], exp_rx[i]);
            if (chk_cs) begin
                check("cs_low_min", (cs_low - c0) >= 128, 1);
                check("cs_low_max", (cs_low - c0) <= 136, 1);
            end
            mbuf.delete();
        end
    endtask

    initial begin
        bq_t rsp;
        int nw, wr, rd;
        sys_rst_n = 1'b0;
        sif.buf_wr_en = 1'b0; sif.buf_wr_data = 8'h00;
        sif.cmd_start = 1'b0; sif.wr_len = 8'h00; sif.rd_len = 8'h00;
        eng_bytes = 0; rsp_base = 0;
        repeat (3) @(negedge sys_clk);
        check("rst_outputs", {sif.busy, sif.done, sif.err, sif.rd_valid, sif.spi_start, sif.spi_end, sif.buf_full}, 0);
        check("rst_data_send", sif.data_send, 0);
        check("rst_buf_cnt", sif.buf_cnt, 0);
        sys_rst_n = 1'b1;
        @(negedge sys_clk);

        write_byte(8'h9F);
        rsp = '{8'h00, 8'hEF, 8'h40, 8'h18};
        run_cmd(1, 3, rsp, 0, 0);

        write_byte(8'h02); write_byte(8'h00); write_byte(8'h10); write_byte(8'hAA);
        rsp = '{8'h11, 8'h22, 8'h33, 8'h44};
        run_cmd(4, 0, rsp, 0, 1);

        rsp = '{8'hC3};
        run_cmd(0, 1, rsp, 0, 0);

        write_byte(8'h01); write_byte(8'h02);
        rsp = '{8'h00, 8'h00, 8'h00};
        run_cmd(3, 0, rsp, 0, 0);
        rsp.delete();
        run_cmd(0, 0, rsp, 0, 0);
        rsp = '{8'h00, 8'h00, 8'h7E};
        run_cmd(2, 1, rsp, 0, 0);

        for (int i = 0; i < 17; i++) write_byte(8'(8'hA0 + i));
        check("full_flag", sif.buf_full, 1);
        check("full_count", sif.buf_cnt, 16);
        rsp.delete();
        for (int i = 0; i < 17; i++) rsp.push_back(8'($urandom));
        run_cmd(16, 1, rsp, 1, 0);

        // reset during byte 2 of a 4-byte read
        @(negedge sys_clk);
        sif.cmd_start = 1'b1; sif.wr_len = 8'd0; sif.rd_len = 8'd4;
        @(negedge sys_clk);
        sif.cmd_start = 1'b0;
        repeat (50) @(negedge sys_clk);
        #2 sys_rst_n = 1'b0;
        #1;
        check("midrst_outputs", {sif.busy, sif.done, sif.err, sif.rd_valid, sif.spi_start, sif.spi_end, sif.buf_full}, 0);
        check("midrst_data_send", sif.data_send, 0);
        check("midrst_rd_data", sif.rd_data, 0);
        @(negedge sys_clk);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        mbuf.delete();
        @(negedge sys_clk);
        write_byte(8'h3C);
        rsp = '{8'h00, 8'h5D, 8'h6E};
        run_cmd(1, 2, rsp, 0, 0);

        for (int t = 0; t < 8; t++) begin
            nw = $urandom_range(0, 5);
            for (int i = 0; i < nw; i++) write_byte(8'($urandom));
            wr = $urandom_range(0, mbuf.size() + 1);
            rd = $urandom_range(0, 4);
            rsp.delete();
            for (int i = 0; i < wr + rd; i++) rsp.push_back(8'($urandom));
            run_cmd(wr, rd, rsp, 0, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
